// File: rtl/gf22_fll_pkg.sv
// Shared constants and types for the GF22 FLL digital core.
// Build option FLL_LOCK_DETECT_EN selects the full lock detector (see gf22_fll.sv).
package gf22_fll_pkg;

  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_CONFIG1 = 2'd1;
  localparam logic [1:0] ADDR_CONFIG2 = 2'd2;
  localparam logic [1:0] ADDR_INTEG   = 2'd3;

  localparam logic [31:0] CONFIG1_RST = 32'h8100_05F5;
  localparam logic [31:0] CONFIG2_RST = 32'h0040_6107;
  localparam logic [31:0] INTEG_RST   = 32'h0100_0000;

  localparam int MODE_BIT  = 31;
  localparam int DCO_LSB   = 16;
  localparam int DCO_W     = 10;
  localparam int MULT_LSB  = 0;
  localparam int MULT_W    = 16;
  localparam int GAIN_LSB  = 0;
  localparam int GAIN_W    = 4;
  localparam int TOL_LSB   = 4;
  localparam int TOL_W     = 8;
  localparam int ACYC_LSB  = 12;
  localparam int DCYC_LSB  = 18;
  localparam int CYC_W     = 6;
  localparam int CFG2_W    = 24;
  localparam int INTEG_LSB = 6;
  localparam int INTEG_W   = 20;

  typedef logic signed [16:0] fll_err_t;

endpackage

// File: rtl/gf22_fll_if.sv
// REQ/ACK configuration port of the FLL; the SoC side is the master.
interface gf22_fll_if;
  logic        CFGREQ;
  logic        CFGWEB;
  logic [1:0]  CFGAD;
  logic [31:0] CFGD;
  logic        CFGACK;
  logic [31:0] CFGQ;

  modport master (output CFGREQ, CFGWEB, CFGAD, CFGD, input CFGACK, CFGQ);
  modport slave  (input CFGREQ, CFGWEB, CFGAD, CFGD, output CFGACK, CFGQ);
endinterface

// File: rtl/gf22_fll_lock_detect.sv
// Lock detector: counts consecutive in/out-of-tolerance measurements with hysteresis.
module fll_lock_detect
  import gf22_fll_pkg::*;
(
  input  logic             fll_cfg_clk,
  input  logic             rstn_glob_i,
  input  fll_err_t         err,
  input  logic             fb_valid,
  input  logic [TOL_W-1:0] tol,
  input  logic [CYC_W-1:0] assert_cyc,
  input  logic [CYC_W-1:0] deassert_cyc,
  input  logic             pwd,
  output logic             lock
);

  logic [CYC_W-1:0] in_cnt, in_cnt_next;
  logic [CYC_W-1:0] out_cnt, out_cnt_next;
  logic             lock_next;
  logic [16:0]      abs_err;
  logic             in_tol;

  assign abs_err = err[16] ? 17'(-err) : 17'(err);
  assign in_tol  = (abs_err <= {9'd0, tol});

  always_comb begin
    in_cnt_next  = in_cnt;
    out_cnt_next = out_cnt;
    lock_next    = lock;
    if (pwd) begin
      in_cnt_next  = '0;
      out_cnt_next = '0;
      lock_next    = 1'b0;
    end else if (fb_valid) begin
      // Each counter saturates at 63 and is cleared by a measurement of the other kind
      if (in_tol) begin
        in_cnt_next  = (in_cnt == '1) ? in_cnt : in_cnt + 1'b1;
        out_cnt_next = '0;
        if (in_cnt_next >= assert_cyc) lock_next = 1'b1;
      end else begin
        out_cnt_next = (out_cnt == '1) ? out_cnt : out_cnt + 1'b1;
        in_cnt_next  = '0;
        if (out_cnt_next >= deassert_cyc) lock_next = 1'b0;
      end
    end
  end

  always_ff @(posedge fll_cfg_clk or negedge rstn_glob_i) begin
    if (!rstn_glob_i) begin
      in_cnt  <= '0;
      out_cnt <= '0;
      lock    <= 1'b0;
    end else begin
      in_cnt  <= in_cnt_next;
      out_cnt <= out_cnt_next;
      lock    <= lock_next;
    end
  end

endmodule

// File: rtl/gf22_fll.sv
// GF22 FLL digital core: config registers, integrating loop, DCO mux and lock output.
// Define FLL_LOCK_DETECT_EN to build the lock detector; otherwise LOCK is registered ~PWD.
module gf22_fll
  import gf22_fll_pkg::*;
(
  input  logic          REFCLK,
  input  logic          RSTB,
  input  logic          PWD,
  gf22_fll_if.slave     cfg,
  input  logic [15:0]   FB_CNT,
  input  logic          FB_VALID,
  output logic [9:0]    DCO_CODE,
  output logic          LOCK
);

  logic [15:0]        status;
  logic               mode;
  logic [DCO_W-1:0]   ol_dco;
  logic [MULT_W-1:0]  mult;
  logic [CFG2_W-1:0]  cfg2;
  logic [INTEG_W-1:0] integ;

  logic               accept;
  logic [31:0]        rd_data;
  fll_err_t           err;
  logic signed [27:0] err_scaled, delta, integ_sum;
  logic [INTEG_W-1:0] integ_sat;

  assign accept = cfg.CFGREQ && !cfg.CFGACK;

  always_comb begin
    rd_data = '0;
    case (cfg.CFGAD)
      ADDR_STATUS:  rd_data = {16'd0, status};
      ADDR_CONFIG1: rd_data = {mode, 5'd0, ol_dco, mult};
      ADDR_CONFIG2: rd_data = {8'd0, cfg2};
      default:      rd_data = {6'd0, integ, 6'd0};
    endcase
  end

  // err*1024 keeps the 10 fractional integrator bits before the gain shift
  always_comb begin
    err        = $signed({1'b0, mult}) - $signed({1'b0, FB_CNT});
    err_scaled = $signed({err[16], err, 10'd0});
    delta      = err_scaled >>> cfg2[GAIN_LSB +: GAIN_W];
    integ_sum  = $signed({8'd0, integ}) + delta;
    integ_sat  = integ_sum[27:20] != 8'd0 ? (integ_sum[27] ? '0 : '1) : integ_sum[19:0];
  end

  // Loop update is ordered before the register write so a software write wins
  always_ff @(posedge REFCLK or negedge RSTB) begin
    if (!RSTB) begin
      status     <= '0;
      mode       <= CONFIG1_RST[MODE_BIT];
      ol_dco     <= CONFIG1_RST[DCO_LSB +: DCO_W];
      mult       <= CONFIG1_RST[MULT_LSB +: MULT_W];
      cfg2       <= CONFIG2_RST[CFG2_W-1:0];
      integ      <= INTEG_RST[INTEG_LSB +: INTEG_W];
      cfg.CFGACK <= 1'b0;
      cfg.CFGQ   <= '0;
    end else begin
      cfg.CFGACK <= accept;
      if (FB_VALID && !PWD) begin
        status <= FB_CNT;
        if (mode) integ <= integ_sat;
      end
      if (accept) begin
        cfg.CFGQ <= rd_data;
        if (!cfg.CFGWEB) begin
          case (cfg.CFGAD)
            ADDR_CONFIG1: begin
              mode   <= cfg.CFGD[MODE_BIT];
              ol_dco <= cfg.CFGD[DCO_LSB +: DCO_W];
              mult   <= cfg.CFGD[MULT_LSB +: MULT_W];
            end
            ADDR_CONFIG2: cfg2  <= cfg.CFGD[CFG2_W-1:0];
            ADDR_INTEG:   integ <= cfg.CFGD[INTEG_LSB +: INTEG_W];
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge REFCLK or negedge RSTB) begin
    if (!RSTB)      DCO_CODE <= CONFIG1_RST[DCO_LSB +: DCO_W];
    else if (PWD)   DCO_CODE <= '0;
    else if (mode)  DCO_CODE <= integ[INTEG_W-1 -: DCO_W];
    else            DCO_CODE <= ol_dco;
  end

`ifdef FLL_LOCK_DETECT_EN
  fll_lock_detect u_lock_detect (
    .fll_cfg_clk  (REFCLK),
    .rstn_glob_i  (RSTB),
    .err          (err),
    .fb_valid     (FB_VALID),
    .tol          (cfg2[TOL_LSB +: TOL_W]),
    .assert_cyc   (cfg2[ACYC_LSB +: CYC_W]),
    .deassert_cyc (cfg2[DCYC_LSB +: CYC_W]),
    .pwd          (PWD),
    .lock         (LOCK)
  );
`else
  always_ff @(posedge REFCLK or negedge RSTB) begin
    if (!RSTB) LOCK <= 1'b0;
    else       LOCK <= !PWD;
  end
`endif

endmodule

// File: tb/tb_gf22_fll.sv
// Directed self-checking bench for gf22_fll with a read-data scoreboard and integrator model.
module tb_gf22_fll;

  logic        refclk;
  logic        rstb;
  logic        pwd;
  logic [15:0] fb_cnt;
  logic        fb_valid;
  logic [9:0]  dco_code;
  logic        lock;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [19:0] m_integ;
  logic [15:0] m_mult;
  logic [3:0]  m_g;

`ifdef FLL_LOCK_DETECT_EN
  localparam bit LD = 1'b1;
`else
  localparam bit LD = 1'b0;
`endif

  gf22_fll_if cfg ();

  gf22_fll dut (
    .REFCLK   (refclk),
    .RSTB     (rstb),
    .PWD      (pwd),
    .cfg      (cfg.slave),
    .FB_CNT   (fb_cnt),
    .FB_VALID (fb_valid),
    .DCO_CODE (dco_code),
    .LOCK     (lock)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Reference model of one closed-loop integrator step with saturation
  function automatic logic [19:0] step(logic [19:0] i, logic [15:0] mult, logic [15:0] fb,
                                       logic [3:0] g);
    longint e, d, s;
    e = longint'(mult) - longint'(fb);
    d = (e * 1024) >>> g;
    s = longint'(i) + d;
    if (s < 0) s = 0;
    if (s > 64'sh FFFFF) s = 64'sh FFFFF;
    return s[19:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // One FB_VALID strobe; returns just after the sampling edge
  task automatic applyStimulus(input logic [15:0] fb);
    fb_cnt   = fb;
    fb_valid = 1'b1;
    tick();
    fb_valid = 1'b0;
  endtask

  // Config access: expected read data is queued at issue and popped on ACK
  task automatic cfg_access(input logic web, input logic [1:0] ad, input logic [31:0] d,
                            input logic [31:0] expected, input string tag);
    int cycles;
    logic [31:0] e;
    if (cfg.CFGACK) tick();
    exp_q.push_back(expected);
    cfg.CFGREQ = 1'b1;
    cfg.CFGWEB = web;
    cfg.CFGAD  = ad;
    cfg.CFGD   = d;
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!cfg.CFGACK && cycles < 10);
    cfg.CFGREQ = 1'b0;
    checkOutput({tag, "_ack_latency"}, 32'(cycles), 32'd1);
    e = exp_q.pop_front();
    checkOutput({tag, "_q"}, cfg.CFGQ, e);
  endtask

  initial begin
    rstb       = 1'b0;
    pwd        = 1'b0;
    fb_cnt     = '0;
    fb_valid   = 1'b0;
    cfg.CFGREQ = 1'b0;
    cfg.CFGWEB = 1'b1;
    cfg.CFGAD  = '0;
    cfg.CFGD   = '0;
    m_integ    = 20'h40000;
    m_mult     = 16'd1525;
    m_g        = 4'd7;
    $display("[TB] start");

    repeat (3) tick();
    checkOutput("rst_ack", 32'(cfg.CFGACK), 32'd0);
    checkOutput("rst_q", cfg.CFGQ, 32'd0);
    checkOutput("rst_lock", 32'(lock), 32'd0);
    checkOutput("rst_dco", 32'(dco_code), 32'h100);
    rstb = 1'b1;
    tick();

    // Reset register readback and one-cycle ACK
    cfg_access(1'b1, 2'd1, 32'd0, 32'h8100_05F5, "rd_cfg1");
    tick();
    checkOutput("ack_one_cycle", 32'(cfg.CFGACK), 32'd0);

    // Open loop: DCO follows CONFIG1, integrator untouched by strobes
    cfg_access(1'b0, 2'd1, 32'h0155_05F5, 32'h8100_05F5, "wr_cfg1_ol");
    tick();
    checkOutput("ol_dco", 32'(dco_code), 32'h155);
    applyStimulus(16'd1000);
    applyStimulus(16'd1397);
    cfg_access(1'b1, 2'd3, 32'd0, 32'h0100_0000, "ol_integ");
    cfg_access(1'b1, 2'd0, 32'd0, 32'd1397, "status");

    // Closed loop single step
    cfg_access(1'b0, 2'd1, 32'h8100_05F5, 32'h0155_05F5, "wr_cfg1_cl");
    tick();
    checkOutput("cl_dco_init", 32'(dco_code), 32'h100);
    applyStimulus(16'd1397);
    m_integ = step(m_integ, m_mult, 16'd1397, m_g);
    tick();
    checkOutput("cl_dco_step", 32'(dco_code), 32'(m_integ[19:10]));
    cfg_access(1'b1, 2'd3, 32'd0, {6'd0, m_integ, 6'd0}, "cl_integ");

    // Lock assert / deassert thresholds with a tiny gain
    cfg_access(1'b0, 2'd2, 32'h0040_610F, 32'h0040_6107, "wr_cfg2_g15");
    m_g = 4'd15;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(16'd1520);
      m_integ = step(m_integ, m_mult, 16'd1520, m_g);
      if (i == 5) checkOutput("lock_after5", 32'(lock), LD ? 32'd0 : 32'd1);
      if (i == 6) checkOutput("lock_after6", 32'(lock), 32'd1);
    end
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(16'd1425);
      m_integ = step(m_integ, m_mult, 16'd1425, m_g);
      if (i == 15) checkOutput("unlock_after15", 32'(lock), 32'd1);
      if (i == 16) checkOutput("unlock_after16", 32'(lock), LD ? 32'd0 : 32'd1);
    end
    tick();
    checkOutput("g15_dco", 32'(dco_code), 32'(m_integ[19:10]));
    cfg_access(1'b1, 2'd3, 32'd0, {6'd0, m_integ, 6'd0}, "g15_integ");

    // Upper saturation
    cfg_access(1'b0, 2'd3, 32'h03FF_FFC0, {6'd0, m_integ, 6'd0}, "wr_integ");
    m_integ = 20'hFFFFF;
    cfg_access(1'b0, 2'd2, 32'h0040_6100, 32'h0040_610F, "wr_cfg2_g0");
    m_g = 4'd0;
    applyStimulus(16'd0);
    m_integ = step(m_integ, m_mult, 16'd0, m_g);
    cfg_access(1'b1, 2'd3, 32'd0, {6'd0, m_integ, 6'd0}, "sat_integ");
    checkOutput("sat_dco", 32'(dco_code), 32'h3FF);

    // Power-down while locked
    for (int i = 0; i < 6; i++) applyStimulus(16'd1525);
    checkOutput("relock", 32'(lock), 32'd1);
    pwd = 1'b1;
    tick();
    checkOutput("pwd_dco", 32'(dco_code), 32'd0);
    checkOutput("pwd_lock", 32'(lock), 32'd0);
    cfg_access(1'b0, 2'd2, 32'h0040_6107, 32'h0040_6100, "pwd_wr_cfg2");
    cfg_access(1'b1, 2'd2, 32'd0, 32'h0040_6107, "pwd_rd_cfg2");
    applyStimulus(16'd1000);
    cfg_access(1'b1, 2'd3, 32'd0, {6'd0, m_integ, 6'd0}, "pwd_integ_held");
    cfg_access(1'b1, 2'd0, 32'd0, 32'd1525, "pwd_status_held");
    pwd = 1'b0;
    tick();
    checkOutput("pwd_exit_dco", 32'(dco_code), 32'(m_integ[19:10]));
    checkOutput("pwd_exit_lock", 32'(lock), LD ? 32'd0 : 32'd1);

    // Reset in the middle of a request aborts it
    tick();
    cfg.CFGREQ = 1'b1;
    cfg.CFGWEB = 1'b1;
    cfg.CFGAD  = 2'd1;
    rstb       = 1'b0;
    tick();
    checkOutput("abort_ack", 32'(cfg.CFGACK), 32'd0);
    checkOutput("abort_dco", 32'(dco_code), 32'h100);
    cfg.CFGREQ = 1'b0;
    rstb       = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf22_fll.md
# gf22_fll

Digital control core of the GF22 frequency-locked loop used by the SoC, peripheral and cluster clock domains in `soc_clk_rst_gen`.
- Runs on the reference clock.
- Exposes the 4-register FLL configuration port (REQ/ACK handshake).
- Closes a first-order integrating loop from a per-reference-period feedback count to a 10-bit DCO code.
- Generates the LOCK indication.

The analog DCO and the feedback counter sit outside this block.

## Interface
Parameters: none; all widths are fixed.

Ports:
- REFCLK in 1: reference clock, the only clock.
- RSTB in 1: asynchronous, active-low reset.
- PWD in 1: power-down, sampled synchronously.
- CFGREQ in 1: config request.
- CFGWEB in 1: 0 = write, 1 = read.
- CFGAD in 2: register address.
- CFGD in 32: write data.
- CFGACK out 1: one-cycle acknowledge.
- CFGQ out 32: read data.
- FB_CNT in 16: DCO cycles counted in the last reference period, already synchronous to REFCLK.
- FB_VALID in 1: one-cycle strobe meaning FB_CNT is new.
- DCO_CODE out 10: DCO control word.
- LOCK out 1: loop locked.

## Operation
Register map:
- 0 STATUS (RO): [15:0] last FB_CNT. Writes ignored. Reset 0.
- 1 CONFIG1: [31] MODE (1 = closed loop), [25:16] open-loop DCO code, [15:0] MULT target. Reset 0x8100_05F5 (MODE=1, DCO=0x100, MULT=1525).
- 2 CONFIG2: [3:0] gain shift G, [11:4] TOL, [17:12] ASSERT_CYC, [23:18] DEASSERT_CYC. Reset 0x0040_6107 (G=7, TOL=16, ASSERT_CYC=6, DEASSERT_CYC=16).
- 3 INTEGRATOR: [25:6] 20-bit integrator (10 integer + 10 fractional bits). Reset 0x0100_0000. Writable.
- Unused bits read 0.

Handshake and register access:
- A request is accepted when CFGREQ=1 and CFGACK=0.
- On acceptance, CFGQ is loaded with the register's pre-write value; a write updates the register on the same edge.
- The requester drops CFGREQ in the cycle it sees CFGACK.

Loop (on FB_VALID while PWD=0):
- err = MULT − FB_CNT, as a 17-bit signed value. STATUS is updated.
- If MODE=1: integ += (err·1024) >>> G (arithmetic shift), then saturate to [0, 0xFFFFF].
- A software write to INTEGRATOR in the same cycle wins over the loop update.

DCO_CODE output:
- MODE=1: integ[19:10].
- MODE=0: CONFIG1[25:16].
- PWD=1: 0.

Lock detector:
- On each FB_VALID, the measurement is in tolerance if |err| ≤ TOL; otherwise it is out of tolerance.
- Consecutive in-tolerance measurements are counted; LOCK sets when the count reaches ASSERT_CYC.
- Consecutive out-of-tolerance measurements are counted; LOCK clears when the count reaches DEASSERT_CYC.
- Each counter clears on a measurement of the opposite kind and saturates at 63.
- The detector runs in both modes.

PWD=1:
- Integrator is held.
- Lock counters are cleared and LOCK=0.
- Config access still works.

## Timing
- All outputs are registered.
- Reset values: CFGACK=0, CFGQ=0, LOCK=0, DCO_CODE=0x100.
- CFGACK goes high exactly 1 cycle after acceptance and stays high for 1 cycle.
- DCO_CODE reflects a FB_VALID update or a register write 1 cycle later.
- LOCK changes 1 cycle after the qualifying FB_VALID.
- Reset during a transaction aborts it; no ACK is issued.

## Configuration
Macro `FLL_LOCK_DETECT_EN`:
- Defined: the lock detector behaves as described above.
- Undefined:
  - LOCK = ~PWD, registered.
  - The CONFIG2 TOL, ASSERT_CYC and DEASSERT_CYC fields remain read/write but have no effect.
  - The detector logic is not built.

## Structure
- Package `gf22_fll_pkg` holds:
  - address constants;
  - register reset values;
  - field LSB/width constants;
  - the 17-bit signed error typedef.
- One sub-module, `fll_lock_detect`:
  - inputs: err, FB_VALID, TOL, ASSERT_CYC, DEASSERT_CYC, PWD;
  - output: LOCK.
- The top level holds the register file, handshake, integrator and DCO mux.

## Test plan
1. Reset → CFGACK=0, LOCK=0, DCO_CODE=0x100. Read addr 1 → CFGQ=0x8100_05F5 with ACK 1 cycle after acceptance.
2. Write addr 1 = 0x0155_05F5 (open loop) → DCO_CODE=0x155 one cycle after ACK. FB_VALID pulses leave INTEGRATOR at 0x0100_0000.
3. Closed loop, G=7, FB_CNT=1397 strobe → err=128, integ += 1024 → DCO_CODE=0x101. INTEGRATOR reads 0x0101_0000.
4. Lock detection (G=15 so the integrator barely moves):
   - Six strobes with FB_CNT=1520 → LOCK rises after the 6th, not the 5th.
   - Then sixteen strobes with FB_CNT=1425 → LOCK falls after the 16th.
5. Write INTEGRATOR = 0x03FF_FFC0, then strobe FB_CNT=0 with G=0 → saturates: reads 0x03FF_FFC0, DCO_CODE=0x3FF.
6. PWD=1 while locked → DCO_CODE=0 and LOCK=0 next cycle. Config write to addr 2 still ACKed. After PWD=0, DCO_CODE returns to integ[19:10].
